// File: rtl/shift_frame_ctrl.sv
// shift_frame_ctrl: sequences a WIDTH-bit full-duplex shift datapath.
// A word accepted over valid/ready is shifted out MSB-first on sout while
// sin is captured into rx; the received word is presented with a one-cycle
// out_valid pulse, followed by GAP idle cycles before the next accept.
module shift_frame_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  input  logic             sin,
  output logic             sout,
  output logic             frame,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // Next-state and datapath update for the frame sequencer
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          tx_d    = in_data;
          rx_d    = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          tx_d = {tx_q[WIDTH-2:0], 1'b0};
          rx_d = {rx_q[WIDTH-2:0], sin};
          if (cnt_q == CNT_LAST) begin
            // Result is captured on the final edge so out_data is already
            // valid during the DONE cycle.
            out_data_d = {rx_q[WIDTH-2:0], sin};
            cnt_d      = '0;
            state_d    = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        gap_d   = '0;
        state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      out_data_q <= out_data_d;
    end
  end

  // Outputs decoded from registered state; in_ready is held low during reset
  always_comb begin
    frame     = (state_q == ST_SHIFT);
    sout      = frame & tx_q[WIDTH-1];
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    in_ready  = (state_q == ST_IDLE) & reset;
    out_data  = out_data_q;
  end

endmodule
